// File: rtl/swap_arb2_ctl_if.sv
// Signal bundle between the round-robin token controller and the swap element's control port.
// The controller holds the master modport; the swap element / environment holds the slave modport.
interface swap_arb2_ctl_if;
    logic req0_i;
    logic req1_i;
    logic rctl_o;
    logic actl_i;
    logic dctl_o;
    logic busy_o;
    logic err_o;

    modport master (
        input  req0_i,
        input  req1_i,
        input  actl_i,
        output rctl_o,
        output dctl_o,
        output busy_o,
        output err_o
    );

    modport slave (
        output req0_i,
        output req1_i,
        output actl_i,
        input  rctl_o,
        input  dctl_o,
        input  busy_o,
        input  err_o
    );
endinterface

// File: rtl/swap_arb2_ctl.sv
// Round-robin select-token generator for a two-input swap/merge element.
// It issues one dctl token per 4-phase rctl/actl handshake, with burst limiting and a sticky timeout flag.
module swap_arb2_ctl #(
    parameter int N_BURST = 1,
    parameter int TIMEOUT = 0,
    parameter int SYNC    = 1
) (
    input  logic            clk,
    input  logic            rst,
    swap_arb2_ctl_if.master bus
);

    localparam int BW = (N_BURST > 0) ? $clog2(N_BURST + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(N_BURST);
    localparam logic [TW-1:0] TIME_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        RTZ   = 2'd3
    } state_t;

    // Input conditioning: bit 0 = req0, bit 1 = req1, bit 2 = actl.
    logic [2:0] raw_in;
    logic [2:0] seen;
    genvar gi;

    assign raw_in = {bus.actl_i, bus.req1_i, bus.req0_i};

    generate
        if (SYNC != 0) begin : g_sync
            for (gi = 0; gi < 3; gi++) begin : g_bit
                logic [1:0] sync_reg;
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        sync_reg <= 2'b00;
                    end else begin
                        sync_reg <= {sync_reg[0], raw_in[gi]};
                    end
                end
                assign seen[gi] = sync_reg[1];
            end
        end else begin : g_raw
            assign seen = raw_in;
        end
    endgenerate

    logic p0;
    logic p1;
    logic ack;

    assign p0  = seen[0];
    assign p1  = seen[1];
    assign ack = seen[2];

    state_t          state_reg, state_next;
    logic            rctl_reg,  rctl_next;
    logic            dctl_reg,  dctl_next;
    logic            busy_reg,  busy_next;
    logic            err_reg,   err_next;
    logic            last_reg,  last_next;
    logic [BW-1:0]   burst_reg, burst_next;
    logic [TW-1:0]   tcnt_reg,  tcnt_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            rctl_reg  <= 1'b0;
            dctl_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b0;
            last_reg  <= 1'b1;
            burst_reg <= '0;
            tcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            rctl_reg  <= rctl_next;
            dctl_reg  <= dctl_next;
            busy_reg  <= busy_next;
            err_reg   <= err_next;
            last_reg  <= last_next;
            burst_reg <= burst_next;
            tcnt_reg  <= tcnt_next;
        end
    end

    // burst_reg==0 only before the first grant; treating it as "no run in progress"
    // makes the reset value last=1 hand the first tie to input 0.
    logic          keep_last;
    logic          win;
    logic [BW-1:0] burst_inc;
    logic [TW-1:0] tcnt_inc;

    always_comb begin
        keep_last = (burst_reg != '0) && (burst_reg < BURST_MAX);
        if (p0 && !p1) begin
            win = 1'b0;
        end else if (p1 && !p0) begin
            win = 1'b1;
        end else if (keep_last) begin
            win = last_reg;
        end else begin
            win = ~last_reg;
        end
    end

    assign burst_inc = (burst_reg >= BURST_MAX) ? BURST_MAX : burst_reg + BW'(1);
    assign tcnt_inc  = (tcnt_reg >= TIME_MAX) ? TIME_MAX : tcnt_reg + TW'(1);

    always_comb begin
        state_next = state_reg;
        rctl_next  = rctl_reg;
        dctl_next  = dctl_reg;
        last_next  = last_reg;
        burst_next = burst_reg;
        tcnt_next  = tcnt_reg;

        case (state_reg)
            IDLE: begin
                if (p0 || p1) begin
                    dctl_next  = win;
                    last_next  = win;
                    burst_next = (win == last_reg) ? burst_inc : BW'(1);
                    state_next = SETUP;
                end
            end
            SETUP: begin
                rctl_next  = 1'b1;
                tcnt_next  = '0;
                state_next = REQ;
            end
            REQ: begin
                if (ack) begin
                    rctl_next  = 1'b0;
                    tcnt_next  = '0;
                    state_next = RTZ;
                end else begin
                    tcnt_next  = tcnt_inc;
                end
            end
            RTZ: begin
                if (!ack) begin
                    state_next = IDLE;
                end else begin
                    tcnt_next  = tcnt_inc;
                end
            end
            default: begin
                rctl_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // The wait is never aborted; err only records that the handshake ran long.
    logic waiting;

    always_comb begin
        waiting   = (state_reg == REQ) || (state_reg == RTZ);
        err_next  = err_reg;
        if ((TIMEOUT != 0) && waiting && (tcnt_next == TIME_MAX)) begin
            err_next = 1'b1;
        end
        busy_next = (state_next != IDLE);
    end

    assign bus.rctl_o = rctl_reg;
    assign bus.dctl_o = dctl_reg;
    assign bus.busy_o = busy_reg;
    assign bus.err_o  = err_reg;

endmodule

// File: tb/tb_swap_arb2_ctl.sv
// Bench for swap_arb2_ctl: two instances (raw inputs with timeout, synchronized inputs with bursts)
// checked every cycle against a transaction-level model plus directed token sequences.
module tb_swap_arb2_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b0;
    logic r0    = 1'b1;
    logic r1    = 1'b1;
    logic ack_a = 1'b0;
    logic ack_b = 1'b0;
    bit   en_a  = 1'b1;
    bit   en_b  = 1'b1;

    int n_pass  = 0;
    int n_total = 0;

    swap_arb2_ctl_if ifa ();
    swap_arb2_ctl_if ifb ();

    assign ifa.req0_i = r0;
    assign ifa.req1_i = r1;
    assign ifa.actl_i = ack_a;
    assign ifb.req0_i = r0;
    assign ifb.req1_i = r1;
    assign ifb.actl_i = ack_b;

    swap_arb2_ctl #(.N_BURST(1), .TIMEOUT(10), .SYNC(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    swap_arb2_ctl #(.N_BURST(3), .TIMEOUT(0), .SYNC(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- model (phase: 0 idle, 1 setup, 2 req, 3 rtz) ----------------
    int nb [2] = '{1, 3};
    int to [2] = '{10, 0};
    int sy [2] = '{0, 1};

    int m_ph   [2];
    int m_bc   [2];
    int m_wait [2];
    bit m_rc   [2];
    bit m_dc   [2];
    bit m_lst  [2];
    bit m_er   [2];
    bit h_a    [2][3];
    bit h_b    [2][3];

    function automatic bit pick(input int d, input bit p0, input bit p1);
        if (p0 && !p1) return 1'b0;
        if (p1 && !p0) return 1'b1;
        if (m_bc[d] > 0 && m_bc[d] < nb[d]) return m_lst[d];
        return !m_lst[d];
    endfunction

    task automatic model_step(input int d, input bit raw0, input bit raw1, input bit rawk);
        bit raw [3];
        bit seen [3];
        bit w;
        raw[0] = raw0;
        raw[1] = raw1;
        raw[2] = rawk;
        if (!rst) begin
            m_ph[d] = 0; m_bc[d] = 0; m_wait[d] = 0;
            m_rc[d] = 0; m_dc[d] = 0; m_lst[d] = 1; m_er[d] = 0;
            for (int i = 0; i < 3; i++) begin
                h_a[d][i] = 0;
                h_b[d][i] = 0;
            end
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (sy[d] != 0) begin
                seen[i]   = h_b[d][i];
                h_b[d][i] = h_a[d][i];
                h_a[d][i] = raw[i];
            end else begin
                seen[i] = raw[i];
            end
        end
        case (m_ph[d])
            0: if (seen[0] || seen[1]) begin
                w = pick(d, seen[0], seen[1]);
                if (w == m_lst[d]) m_bc[d] = (m_bc[d] < nb[d]) ? m_bc[d] + 1 : nb[d];
                else               m_bc[d] = 1;
                m_lst[d] = w;
                m_dc[d]  = w;
                m_ph[d]  = 1;
            end
            1: begin m_rc[d] = 1; m_ph[d] = 2; m_wait[d] = 0; end
            2: if (seen[2]) begin m_rc[d] = 0; m_ph[d] = 3; m_wait[d] = 0; end
               else m_wait[d]++;
            default: if (!seen[2]) m_ph[d] = 0; else m_wait[d]++;
        endcase
        if (to[d] != 0 && (m_ph[d] == 2 || m_ph[d] == 3) && m_wait[d] >= to[d]) m_er[d] = 1;
    endtask

    always @(posedge clk) begin
        model_step(0, r0, r1, ack_a);
        model_step(1, r0, r1, ack_b);
    end

    // Handshake responders: ack mirrors rctl one cycle later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (en_a) ack_a = ifa.rctl_o;
            if (en_b) ack_b = ifb.rctl_o;
        end
    end

    // ---------------- per-cycle compare and token recording ----------------
    bit qa[$];
    bit qb[$];
    bit prev_rc_a = 1'b0;
    bit prev_rc_b = 1'b0;

    always @(negedge clk) begin
        chk("rctl_a", ifa.rctl_o, m_rc[0]);
        chk("dctl_a", ifa.dctl_o, m_dc[0]);
        chk("busy_a", ifa.busy_o, (m_ph[0] != 0));
        chk("err_a",  ifa.err_o,  m_er[0]);
        chk("rctl_b", ifb.rctl_o, m_rc[1]);
        chk("dctl_b", ifb.dctl_o, m_dc[1]);
        chk("busy_b", ifb.busy_o, (m_ph[1] != 0));
        chk("err_b",  ifb.err_o,  m_er[1]);
        if (ifa.rctl_o === 1'b1 && !prev_rc_a) qa.push_back(ifa.dctl_o);
        if (ifb.rctl_o === 1'b1 && !prev_rc_b) qb.push_back(ifb.dctl_o);
        prev_rc_a = (ifa.rctl_o === 1'b1);
        prev_rc_b = (ifb.rctl_o === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input logic q0, input logic q1);
        @(negedge clk);
        rst = 1'b0;
        r0  = q0;
        r1  = q1;
        @(negedge clk);
        rst = 1'b1;
        qa.delete();
        qb.delete();
    endtask

    task automatic wait_tok(input int d, input int k, input int budget, input string name);
        int c = 0;
        while (((d == 0) ? qa.size() : qb.size()) < k && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, (((d == 0) ? qa.size() : qb.size()) >= k), 1);
    endtask

    task automatic chk_seq(input int d, input string name, input logic [15:0] exp, input int n);
        bit got;
        for (int i = 0; i < n; i++) begin
            got = (d == 0) ? ((i < qa.size()) ? qa[i] : 1'b0) : ((i < qb.size()) ? qb[i] : 1'b0);
            chk($sformatf("%s[%0d]", name, i), got, exp[n-1-i]);
        end
    endtask

    task automatic wait_rctl_a(input int budget, input string name);
        int c = 0;
        while (ifa.rctl_o !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, ifa.rctl_o, 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        // Reset held 3 cycles with both requests high.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_rctl_a", ifa.rctl_o, 0);
            chk("rst_dctl_a", ifa.dctl_o, 0);
            chk("rst_busy_a", ifa.busy_o, 0);
            chk("rst_err_a",  ifa.err_o,  0);
            chk("rst_rctl_b", ifb.rctl_o, 0);
            chk("rst_dctl_b", ifb.dctl_o, 0);
            chk("rst_busy_b", ifb.busy_o, 0);
            chk("rst_err_b",  ifb.err_o,  0);
        end

        // Single requester on input 1.
        do_reset(1'b0, 1'b1);
        wait_tok(0, 3, 100, "single_wait_a");
        wait_tok(1, 3, 100, "single_wait_b");
        chk_seq(0, "single_a", 16'b111, 3);
        chk_seq(1, "single_b", 16'b111, 3);

        // Both held high: strict alternation vs bursts of three.
        do_reset(1'b1, 1'b1);
        wait_tok(0, 8, 200, "rr_wait_a");
        wait_tok(1, 8, 400, "burst_wait_b");
        chk_seq(0, "rr_a",    16'b01010101, 8);
        chk_seq(1, "burst_b", 16'b00011100, 8);

        // Input 1 withdraws after its first token: input 0 continues uncontested.
        do_reset(1'b1, 1'b1);
        wait_tok(1, 4, 200, "drop_wait1_b");
        r1 = 1'b0;
        wait_tok(1, 7, 200, "drop_wait2_b");
        chk_seq(1, "drop_b", 16'b0001000, 7);

        // Handshake timeout on dut_a: no acknowledge for a long time.
        en_a  = 1'b0;
        ack_a = 1'b0;
        do_reset(1'b0, 1'b0);
        r0 = 1'b1;
        wait_rctl_a(20, "to_rise_a");
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            chk("to_err_early_a", ifa.err_o, 0);
        end
        @(negedge clk);
        chk("to_err_set_a", ifa.err_o, 1);
        repeat (5) @(negedge clk);
        chk("to_err_hold_a",  ifa.err_o,  1);
        chk("to_rctl_hold_a", ifa.rctl_o, 1);
        en_a = 1'b1;
        r0   = 1'b0;
        begin
            int c = 0;
            while (ifa.busy_o !== 1'b0 && c < 30) begin
                @(negedge clk);
                c++;
            end
        end
        chk("to_done_busy_a",  ifa.busy_o, 0);
        chk("to_done_rctl_a",  ifa.rctl_o, 0);
        chk("to_err_sticky_a", ifa.err_o,  1);

        // Reset while dut_a sits in REQ with err already raised.
        en_a  = 1'b0;
        ack_a = 1'b0;
        do_reset(1'b1, 1'b1);
        wait_rctl_a(20, "mid_rise_a");
        repeat (12) @(negedge clk);
        chk("mid_err_before_a", ifa.err_o, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rctl_a", ifa.rctl_o, 0);
        chk("mid_busy_a", ifa.busy_o, 0);
        chk("mid_err_a",  ifa.err_o,  0);
        chk("mid_dctl_a", ifa.dctl_o, 0);
        rst  = 1'b1;
        en_a = 1'b1;
        qa.delete();
        wait_tok(0, 1, 50, "mid_wait_a");
        chk_seq(0, "mid_first_a", 16'b0, 1);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
